dmem_responder: RTL



---
 rtl/dmem_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Word-organised data-memory responder for the CPU load/store port.
// One request at a time, programmable wait states, registered response.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int IW = ADDR_W - 2;
    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef logic [31:0] mem_t [DEPTH];

    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = 32'(i);
        end
        return m;
    endfunction

    // Storage keeps its content across reset; power-up image is word i = i.
    mem_t mem_q = mem_init();

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              rdy_q, rdy_d;
    logic              vld_q, vld_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept;
    logic              go;
    logic              a_write;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic [3:0]        a_be;
    logic [IW-1:0]     idx;
    logic [AW-1:0]     widx;
    logic              a_err;
    logic              we;
    logic [31:0]       rd_word;

    assign accept = (state_q == S_IDLE) && req_valid && rdy_q;

    // With zero wait states the access uses the request as it is accepted.
    assign go = (WAIT_CYCLES == 0) ? accept
              : ((state_q == S_WAIT) && (cnt_q == '0));

    assign a_write = (WAIT_CYCLES == 0) ? req_write : wr_q;
    assign a_addr  = (WAIT_CYCLES == 0) ? req_addr  : addr_q;
    assign a_wdata = (WAIT_CYCLES == 0) ? req_wdata : wdata_q;
    assign a_be    = (WAIT_CYCLES == 0) ? req_be    : be_q;

    assign idx     = a_addr[ADDR_W-1:2];
    assign widx    = idx[AW-1:0];
    assign a_err   = (a_addr[1:0] != 2'b00) || (idx >= IW'(DEPTH));
    assign we      = go && a_write && !a_err;
    assign rd_word = mem_q[widx];

    // Next-state and registered-output logic of the request/response FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdy_d   = rdy_q;
        vld_d   = vld_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                rdy_d = 1'b1;
                if (accept) begin
                    rdy_d   = 1'b0;
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (!vld_q) begin
                    vld_d = 1'b1;
                end else if (rsp_ready) begin
                    vld_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (go) begin
            rdata_d = (a_write || a_err) ? 32'h0 : rd_word;
            err_d   = a_err;
        end
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-lane store into the array at the access edge.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (we && a_be[k]) begin
                mem_q[widx][8*k +: 8] <= a_wdata[8*k +: 8];
            end
        end
    end

    assign req_ready = rdy_q;
    assign rsp_valid = vld_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
